// File: rtl/ysyx_25040129_axi_mem_responder_if.sv
// ---------------------------------------------------------------------------
// ysyx_25040129_axi_mem_responder_if
// Purpose : AXI4-subset channel bundle between an initiator (MMU/LSU) and the
//           memory responder. It carries AR/R (bursts) and AW/W/B (single-beat).
// Modports: master - drives AR/AW/W requests plus rready/bready.
//           slave  - drives arready/awready/wready and the R/B responses.
// ---------------------------------------------------------------------------
interface ysyx_25040129_axi_mem_responder_if;
   logic [31:0] araddr;
   logic        arvalid;
   logic [2:0]  arsize;
   logic [7:0]  arlen;
   logic [1:0]  arburst;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic        rlast;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport slave (
      input  araddr, arvalid, arsize, arlen, arburst,
      output arready,
      output rdata, rresp, rvalid, rlast,
      input  rready,
      input  awaddr, awvalid,
      output awready,
      input  wdata, wstrb, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready
   );

   modport master (
      output araddr, arvalid, arsize, arlen, arburst,
      input  arready,
      input  rdata, rresp, rvalid, rlast,
      output rready,
      output awaddr, awvalid,
      input  awready,
      output wdata, wstrb, wvalid,
      input  wready,
      input  bresp, bvalid,
      output bready
   );
endinterface

// File: rtl/ysyx_25040129_axi_mem_responder.sv
// ---------------------------------------------------------------------------
// ysyx_25040129_axi_mem_responder
// Purpose : AXI4-subset slave backed by an on-chip word memory. Reads support
//           FIXED/INCR bursts with a programmable first-beat latency; writes are
//           single beat with byte strobes. Read and write FSMs run independently.
// Ports   : clk  - clock, everything on posedge
//           rst  - synchronous active-high reset (memory contents preserved)
//           bus  - slave modport of the AR/R/AW/W/B channel bundle
// ---------------------------------------------------------------------------
module ysyx_25040129_axi_mem_responder #(
   parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          RD_LATENCY  = 2
) (
   input  logic clk,
   input  logic rst,
   ysyx_25040129_axi_mem_responder_if.slave bus
);

   localparam int          IDX_W      = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);
   // R_WAIT holds for RD_LATENCY-1 cycles; the counter runs down to zero.
   localparam logic [3:0]  WAIT_LOAD  = (RD_LATENCY > 1) ? 4'(RD_LATENCY - 2) : 4'd0;

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;

   // ---------------- read-side state ----------------
   r_state_t    r_state_q;
   logic [31:0] raddr_q;
   logic [7:0]  rlen_q, rbeat_q;
   logic [2:0]  rsize_q;
   logic [1:0]  rburst_q;
   logic [3:0]  rlat_q;
   logic        arready_q, rvalid_q, rlast_q;
   logic [1:0]  rresp_q;
   logic [31:0] rdata_w;

   // ---------------- write-side state ----------------
   w_state_t    w_state_q;
   logic [31:0] awaddr_q, wdata_q;
   logic [3:0]  wstrb_q;
   logic        aw_got_q, w_got_q;
   logic        awready_q, wready_q, bvalid_q;
   logic [1:0]  bresp_q;

   logic ar_hs, r_hs, aw_hs, w_hs;
   assign ar_hs = bus.arvalid && arready_q;
   assign r_hs  = rvalid_q && bus.rready;
   assign aw_hs = bus.awvalid && awready_q;
   assign w_hs  = bus.wvalid && wready_q;

   // Address of the next beat: FIXED repeats the address, INCR steps by size.
   logic [31:0] raddr_d;
   logic [7:0]  rbeat_d;
   assign raddr_d = (rburst_q == 2'b01) ? raddr_q + (32'd1 << rsize_q) : raddr_q;
   assign rbeat_d = rbeat_q + 8'd1;

   // A fetch loads the registered beat (data, resp, last) from whichever
   // address is about to be presented, so consecutive beats have no bubble.
   logic [31:0] fetch_addr_d;
   logic [1:0]  fetch_burst_d;
   logic        fetch_en_d, fetch_last_d;

   always_comb begin
      fetch_addr_d  = raddr_q;
      fetch_burst_d = rburst_q;
      fetch_en_d    = 1'b0;
      fetch_last_d  = 1'b0;
      case (r_state_q)
         R_IDLE: begin
            fetch_addr_d  = bus.araddr;
            fetch_burst_d = bus.arburst;
            fetch_en_d    = ar_hs && (RD_LATENCY == 1);
            fetch_last_d  = (bus.arlen == 8'd0);
         end
         R_WAIT: begin
            fetch_en_d   = (rlat_q == 4'd0);
            fetch_last_d = (rlen_q == 8'd0);
         end
         R_DATA: begin
            fetch_addr_d = raddr_d;
            fetch_en_d   = r_hs && !rlast_q;
            fetch_last_d = (rbeat_d == rlen_q);
         end
         default: ;
      endcase
   end

   // Unsigned offset compare covers both below-base and above-top addresses.
   logic [31:0]      rd_off, wr_off;
   logic             rd_ok, wr_ok, rd_burst_ok, wr_en;
   logic [IDX_W-1:0] rd_idx, wr_idx;
   assign rd_off      = fetch_addr_d - ADDR_BASE;
   assign rd_ok       = rd_off < SPAN_BYTES;
   assign rd_idx      = rd_off[IDX_W+1:2];
   assign rd_burst_ok = (fetch_burst_d == 2'b00) || (fetch_burst_d == 2'b01);
   assign wr_off      = awaddr_q - ADDR_BASE;
   assign wr_ok       = wr_off < SPAN_BYTES;
   assign wr_idx      = wr_off[IDX_W+1:2];
   // Reset during W_COMMIT suppresses the write so an aborted write leaves no trace.
   assign wr_en       = (w_state_q == W_COMMIT) && !rst && wr_ok;

   // One byte-wide RAM per lane: strobed writes, registered read. A read and a
   // commit to the same word in one cycle return the pre-write byte.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_mem_q [DEPTH_WORDS];
         logic [7:0] lane_rd_q;

         always_ff @(posedge clk) begin
            if (wr_en && wstrb_q[gi]) begin
               lane_mem_q[wr_idx] <= wdata_q[gi*8 +: 8];
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               lane_rd_q <= 8'h00;
            end else if (fetch_en_d) begin
               lane_rd_q <= (rd_ok && rd_burst_ok) ? lane_mem_q[rd_idx] : 8'h00;
            end
         end

         assign rdata_w[gi*8 +: 8] = lane_rd_q;
      end
   endgenerate

   // ---------------- read FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state_q <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rresp_q   <= 2'b00;
         raddr_q   <= '0;
         rlen_q    <= '0;
         rbeat_q   <= '0;
         rsize_q   <= '0;
         rburst_q  <= '0;
         rlat_q    <= '0;
      end else begin
         if (fetch_en_d) begin
            rlast_q <= fetch_last_d;
            if (!rd_burst_ok)  rresp_q <= 2'b10;
            else if (!rd_ok)   rresp_q <= 2'b11;
            else               rresp_q <= 2'b00;
         end
         case (r_state_q)
            R_IDLE: begin
               arready_q <= 1'b1;
               if (ar_hs) begin
                  arready_q <= 1'b0;
                  raddr_q   <= bus.araddr;
                  rlen_q    <= bus.arlen;
                  rsize_q   <= bus.arsize;
                  rburst_q  <= bus.arburst;
                  rbeat_q   <= 8'd0;
                  rlat_q    <= WAIT_LOAD;
                  if (RD_LATENCY == 1) begin
                     r_state_q <= R_DATA;
                     rvalid_q  <= 1'b1;
                  end else begin
                     r_state_q <= R_WAIT;
                  end
               end
            end
            R_WAIT: begin
               if (rlat_q == 4'd0) begin
                  r_state_q <= R_DATA;
                  rvalid_q  <= 1'b1;
               end else begin
                  rlat_q <= rlat_q - 4'd1;
               end
            end
            R_DATA: begin
               if (r_hs) begin
                  if (rlast_q) begin
                     r_state_q <= R_IDLE;
                     rvalid_q  <= 1'b0;
                     rlast_q   <= 1'b0;
                     arready_q <= 1'b1;
                  end else begin
                     rbeat_q <= rbeat_d;
                     raddr_q <= raddr_d;
                  end
               end
            end
            default: r_state_q <= R_IDLE;
         endcase
      end
   end

   // ---------------- write FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_q <= W_IDLE;
         aw_got_q  <= 1'b0;
         w_got_q   <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else begin
         case (w_state_q)
            W_IDLE: begin
               if (aw_hs) begin
                  awaddr_q  <= bus.awaddr;
                  aw_got_q  <= 1'b1;
                  awready_q <= 1'b0;
               end else begin
                  awready_q <= !aw_got_q;
               end
               if (w_hs) begin
                  wdata_q  <= bus.wdata;
                  wstrb_q  <= bus.wstrb;
                  w_got_q  <= 1'b1;
                  wready_q <= 1'b0;
               end else begin
                  wready_q <= !w_got_q;
               end
               if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
                  w_state_q <= W_COMMIT;
               end
            end
            W_COMMIT: begin
               bresp_q   <= wr_ok ? 2'b00 : 2'b11;
               bvalid_q  <= 1'b1;
               w_state_q <= W_RESP;
            end
            W_RESP: begin
               if (bus.bready) begin
                  bvalid_q  <= 1'b0;
                  aw_got_q  <= 1'b0;
                  w_got_q   <= 1'b0;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
                  w_state_q <= W_IDLE;
               end
            end
            default: w_state_q <= W_IDLE;
         endcase
      end
   end

   assign bus.arready = arready_q;
   assign bus.rdata   = rdata_w;
   assign bus.rresp   = rresp_q;
   assign bus.rvalid  = rvalid_q;
   assign bus.rlast   = rlast_q;
   assign bus.awready = awready_q;
   assign bus.wready  = wready_q;
   assign bus.bresp   = bresp_q;
   assign bus.bvalid  = bvalid_q;

endmodule
